// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - Address/strobe and interrupt handshake bundle for interrupt_controller
//
// Signals:
//   BUS_ADDR      shared address bus
//   BUS_WE        processor write strobe
//   SRC_RAISE     per-source interrupt requests
//   SRC_ACK       per-source one-cycle acknowledge pulses
//   CPU_INT_RAISE interrupt request to the processor
//   CPU_INT_ACK   one-cycle acknowledge from the processor
// BUS_DATA is tri-state and stays a plain inout port on the controller.
interface interrupt_controller_if #(
    parameter int NUM_SRC = 8
);
    logic [7:0]         BUS_ADDR;
    logic               BUS_WE;
    logic [NUM_SRC-1:0] SRC_RAISE;
    logic [NUM_SRC-1:0] SRC_ACK;
    logic               CPU_INT_RAISE;
    logic               CPU_INT_ACK;

    // Processor and peripheral side.
    modport master (
        output BUS_ADDR, BUS_WE, SRC_RAISE, CPU_INT_ACK,
        input  SRC_ACK, CPU_INT_RAISE
    );

    // Interrupt controller side.
    modport slave (
        input  BUS_ADDR, BUS_WE, SRC_RAISE, CPU_INT_ACK,
        output SRC_ACK, CPU_INT_RAISE
    );
endinterface

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - Bus-mapped fixed-priority interrupt controller
//
// Ports:
//   CLK       system clock
//   RESET     synchronous active-high reset
//   BUS_DATA  8-bit shared data bus, driven only in the cycle after a window read
//   bus       interrupt_controller_if.slave (address, write strobe, source
//             requests/acks, processor request/ack)
//
// Register window at BASE_ADDR:
//   +0 PENDING (read, write-1-to-clear)  +1 MASK (R/W)
//   +2 VECTOR {in_service,4'b0,isr_idx} +3 EDGE_MODE (R/W, 1=rising edge)
//   +4 EOI (write any value, reads 0)
module interrupt_controller #(
    parameter int         NUM_SRC   = 8,
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    inout  wire  [7:0]              BUS_DATA,
    interrupt_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAISED  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] edge_mode;
    logic [NUM_SRC-1:0] raise_hist;
    logic [NUM_SRC-1:0] src_ack;
    logic [NUM_SRC-1:0] src_ack_next;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] w1c_clr;
    logic [NUM_SRC-1:0] set_bits;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] wr_data;
    logic [2:0]         isr_idx;
    logic [2:0]         isr_idx_next;
    logic [2:0]         winner;
    logic               cpu_raise;

    logic [7:0]         offset;
    logic               in_win;
    logic               wr_pend;
    logic               wr_mask;
    logic               wr_edge;
    logic               wr_eoi;

    logic               rd_en;
    logic [7:0]         rd_data;
    logic [7:0]         rd_mux;

    // Address decode; offsets 0..4 form the window.
    assign offset  = bus.BUS_ADDR - BASE_ADDR;
    assign in_win  = (offset < 8'd5);
    assign wr_pend = bus.BUS_WE && (offset == 8'd0);
    assign wr_mask = bus.BUS_WE && (offset == 8'd1);
    assign wr_edge = bus.BUS_WE && (offset == 8'd3);
    assign wr_eoi  = bus.BUS_WE && (offset == 8'd4);
    assign wr_data = BUS_DATA[NUM_SRC-1:0];

    assign req     = pending & mask;
    assign w1c_clr = wr_pend ? wr_data : '0;

    // Edge-mode sources only set on a 0->1 step of the request line;
    // level-mode sources set on every cycle the line is high.
    assign set_bits = bus.SRC_RAISE & ~(edge_mode & raise_hist);

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_comb begin
        state_next   = state;
        isr_idx_next = isr_idx;
        src_ack_next = '0;
        ack_clr      = '0;
        cpu_raise    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = RAISED;
                end
            end
            RAISED: begin
                cpu_raise = 1'b1;
                // A withdrawn request (W1C or mask write) takes priority
                // over an acknowledge arriving in the same cycle.
                if (!(|req)) begin
                    state_next = IDLE;
                end else if (bus.CPU_INT_ACK) begin
                    isr_idx_next = winner;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        ack_clr[i] = (winner == 3'(i));
                    end
                    src_ack_next = ack_clr;
                    state_next   = SERVICE;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (offset[2:0])
            3'd0: rd_mux[NUM_SRC-1:0] = pending;
            3'd1: rd_mux[NUM_SRC-1:0] = mask;
            3'd2: rd_mux = {(state == SERVICE), 4'b0000, isr_idx};
            3'd3: rd_mux[NUM_SRC-1:0] = edge_mode;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            pending    <= '0;
            mask       <= '0;
            edge_mode  <= '0;
            raise_hist <= '0;
            isr_idx    <= '0;
            src_ack    <= '0;
            rd_en      <= 1'b0;
            rd_data    <= '0;
        end else begin
            state      <= state_next;
            isr_idx    <= isr_idx_next;
            src_ack    <= src_ack_next;
            raise_hist <= bus.SRC_RAISE;
            // Clears first, then sets, so a new event is never lost.
            pending    <= (pending & ~(w1c_clr | ack_clr)) | set_bits;
            if (wr_mask) begin
                mask <= wr_data;
            end
            if (wr_edge) begin
                edge_mode <= wr_data;
            end
            rd_en   <= in_win && !bus.BUS_WE;
            rd_data <= rd_mux;
        end
    end

    assign BUS_DATA          = rd_en ? rd_data : 8'hzz;
    assign bus.SRC_ACK       = src_ack;
    assign bus.CPU_INT_RAISE = cpu_raise;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - Self-checking bench for interrupt_controller
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst;
    wire  [7:0] bus_data;
    logic       tb_drv;
    logic [7:0] tb_wdata;

    always #5 clk = ~clk;

    assign bus_data = tb_drv ? tb_wdata : 8'hzz;

    interrupt_controller_if #(.NUM_SRC(8)) bus_if ();

    interrupt_controller #(
        .NUM_SRC   (8),
        .BASE_ADDR (8'hE0)
    ) dut (
        .CLK      (clk),
        .RESET    (rst),
        .BUS_DATA (bus_data),
        .bus      (bus_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: register contents as the spec describes them.
    logic [7:0] m_pend, m_mask, m_edge, m_hist, m_ack, m_rdd;
    logic       m_rdv;
    int         m_idx;
    int         m_mode;   // 0 waiting, 1 requesting, 2 in service

    logic       obs_irq;
    logic [7:0] obs_ack;
    logic [7:0] obs_bus;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // then advance the model across the clock edge.
    // op: 0 = no write, 1 = write, 2 = read (any op with WE=0 reads if in window)
    task automatic step(input logic r, input logic [7:0] raise, input int op,
                        input logic [7:0] addr, input logic [7:0] wd, input logic ack);
        logic [7:0] req, set, clr, view, low, off, n_ack;
        logic       in_win;
        int         n_mode, n_idx;
        @(negedge clk);
        rst                = r;
        bus_if.SRC_RAISE   = raise;
        bus_if.BUS_ADDR    = addr;
        bus_if.BUS_WE      = (op == 1);
        bus_if.CPU_INT_ACK = ack;
        tb_drv             = (op == 1);
        tb_wdata           = wd;
        #1;
        obs_irq = bus_if.CPU_INT_RAISE;
        obs_ack = bus_if.SRC_ACK;
        obs_bus = bus_data;
        check_eq("cpu_int_raise", 8'(obs_irq), 8'(m_mode == 1));
        check_eq("src_ack", obs_ack, m_ack);
        if (m_rdv) check_eq("rd_data", obs_bus, m_rdd);
        if (op == 1) check_eq("wr_bus_free", obs_bus, wd);

        off    = addr - 8'hE0;
        in_win = (off < 8'd5);
        req    = m_pend & m_mask;
        for (int i = 0; i < 8; i++)
            set[i] = m_edge[i] ? (raise[i] && !m_hist[i]) : raise[i];
        clr    = (op == 1 && off == 8'd0) ? wd : 8'h00;
        case (off)
            8'd0:    view = m_pend;
            8'd1:    view = m_mask;
            8'd2:    view = {(m_mode == 2), 4'b0000, 3'(m_idx)};
            8'd3:    view = m_edge;
            default: view = 8'h00;
        endcase
        n_mode = m_mode;
        n_idx  = m_idx;
        n_ack  = 8'h00;
        if (m_mode == 0) begin
            if (req != 0) n_mode = 1;
        end else if (m_mode == 1) begin
            if (req == 0) n_mode = 0;
            else if (ack) begin
                low    = req & (~req + 8'd1);
                n_idx  = $clog2(low);
                clr    = clr | low;
                n_ack  = low;
                n_mode = 2;
            end
        end else begin
            if (op == 1 && off == 8'd4) n_mode = 0;
        end

        @(posedge clk);
        if (r) begin
            m_pend = 0; m_mask = 0; m_edge = 0; m_hist = 0; m_ack = 0;
            m_rdd = 0; m_rdv = 0; m_idx = 0; m_mode = 0;
        end else begin
            m_pend = (m_pend & ~clr) | set;
            if (op == 1 && off == 8'd1) m_mask = wd;
            if (op == 1 && off == 8'd3) m_edge = wd;
            m_hist = raise;
            m_ack  = n_ack;
            m_idx  = n_idx;
            m_mode = n_mode;
            m_rdv  = in_win && (op != 1);
            m_rdd  = view;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(1'b0, 8'h00, 1, a, d, 1'b0);
    endtask

    task automatic ack1();
        step(1'b0, 8'h00, 0, 8'h00, 8'h00, 1'b1);
    endtask

    // Read, then spend the response cycle idle; obs_bus holds the response.
    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        step(1'b0, 8'h00, 2, a, 8'h00, 1'b0);
        idle(1);
        check_eq(tag, obs_bus, exp);
    endtask

    initial begin
        logic [7:0] raise, addr, wd;
        logic       r, ack;
        int         op, sel;

        rst = 1'b1; tb_drv = 1'b0; tb_wdata = 8'h00;
        bus_if.SRC_RAISE = 8'h00; bus_if.BUS_ADDR = 8'h00;
        bus_if.BUS_WE = 1'b0; bus_if.CPU_INT_ACK = 1'b0;
        m_pend = 0; m_mask = 0; m_edge = 0; m_hist = 0; m_ack = 0;
        m_rdd = 0; m_rdv = 0; m_idx = 0; m_mode = 0;

        // Reset state
        step(1'b1, 8'h00, 0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 8'h00, 0, 8'h00, 8'h00, 1'b0);
        idle(1);
        check_eq("rst_irq", 8'(obs_irq), 8'h00);
        check_eq("rst_ack", obs_ack, 8'h00);
        rd_chk("rst_pend", 8'hE0, 8'h00);
        rd_chk("rst_vec", 8'hE2, 8'h00);

        // Single level pulse on source 1
        wr(8'hE1, 8'h03);
        step(1'b0, 8'h02, 0, 8'h00, 8'h00, 1'b0);
        idle(1);
        check_eq("t1_irq_early", 8'(obs_irq), 8'h00);
        idle(1);
        check_eq("t1_irq", 8'(obs_irq), 8'h01);
        rd_chk("t1_pend", 8'hE0, 8'h02);
        ack1();
        idle(1);
        check_eq("t1_src_ack", obs_ack, 8'h02);
        check_eq("t1_irq_drop", 8'(obs_irq), 8'h00);
        idle(1);
        check_eq("t1_ack_1cyc", obs_ack, 8'h00);
        rd_chk("t1_vec", 8'hE2, 8'h81);
        wr(8'hE4, 8'h00);
        idle(2);

        // Two simultaneous sources: priority then re-raise after EOI
        step(1'b0, 8'h03, 0, 8'h00, 8'h00, 1'b0);
        idle(2);
        check_eq("t2_irq", 8'(obs_irq), 8'h01);
        ack1();
        idle(1);
        check_eq("t2_ack0", obs_ack, 8'h01);
        rd_chk("t2_vec0", 8'hE2, 8'h80);
        wr(8'hE4, 8'h5A);
        idle(2);
        check_eq("t2_reraise", 8'(obs_irq), 8'h01);
        ack1();
        idle(1);
        check_eq("t2_ack1", obs_ack, 8'h02);
        rd_chk("t2_vec1", 8'hE2, 8'h81);
        rd_chk("t2_pend", 8'hE0, 8'h00);
        wr(8'hE4, 8'h00);

        // Edge mode: held request pends once
        wr(8'hE3, 8'h01);
        for (int i = 0; i < 20; i++)
            step(1'b0, 8'h01, (i == 9) ? 1 : 0, (i == 9) ? 8'hE4 : 8'h00, 8'h00, (i == 5));
        check_eq("t3_no_reraise", 8'(obs_irq), 8'h00);
        step(1'b0, 8'h01, 2, 8'hE0, 8'h00, 1'b0);
        step(1'b0, 8'h01, 0, 8'h00, 8'h00, 1'b0);
        check_eq("t3_pend_once", obs_bus, 8'h00);
        step(1'b0, 8'h00, 0, 8'h00, 8'h00, 1'b0);
        step(1'b0, 8'h01, 0, 8'h00, 8'h00, 1'b0);
        idle(2);
        check_eq("t3_new_edge", 8'(obs_irq), 8'h01);
        ack1();
        wr(8'hE4, 8'h00);
        wr(8'hE3, 8'h00);

        // Masked source latches; unmask raises; W1C withdraws
        wr(8'hE1, 8'h00);
        step(1'b0, 8'h04, 0, 8'h00, 8'h00, 1'b0);
        idle(3);
        check_eq("t4_masked", 8'(obs_irq), 8'h00);
        rd_chk("t4_pend", 8'hE0, 8'h04);
        wr(8'hE1, 8'h04);
        idle(2);
        check_eq("t4_unmask", 8'(obs_irq), 8'h01);
        wr(8'hE0, 8'h04);
        idle(2);
        check_eq("t4_withdraw", 8'(obs_irq), 8'h00);
        rd_chk("t4_pend_clr", 8'hE0, 8'h00);

        // W1C collides with new level request: set wins
        wr(8'hE1, 8'h01);
        step(1'b0, 8'h01, 0, 8'h00, 8'h00, 1'b0);
        step(1'b0, 8'h01, 1, 8'hE0, 8'h01, 1'b0);
        rd_chk("t5_set_wins", 8'hE0, 8'h01);
        ack1();
        wr(8'hE4, 8'h00);
        idle(1);

        // Reset while in service
        wr(8'hE1, 8'hFF);
        step(1'b0, 8'h0F, 0, 8'h00, 8'h00, 1'b0);
        idle(1);
        step(1'b0, 8'h0F, 0, 8'h00, 8'h00, 1'b1);
        idle(1);
        check_eq("t6_ack", obs_ack, 8'h01);
        rd_chk("t6_pend", 8'hE0, 8'h0F);
        step(1'b1, 8'h00, 0, 8'h00, 8'h00, 1'b0);
        idle(1);
        check_eq("t6_irq", 8'(obs_irq), 8'h00);
        check_eq("t6_ack0", obs_ack, 8'h00);
        rd_chk("t6_pend0", 8'hE0, 8'h00);
        rd_chk("t6_mask0", 8'hE1, 8'h00);
        rd_chk("t6_vec0", 8'hE2, 8'h00);
        wr(8'h10, 8'hA5);
        check_eq("t6_bus_z", obs_bus, 8'hA5);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            r     = ($urandom_range(299) == 0);
            raise = 8'($urandom & $urandom & $urandom);
            sel   = $urandom_range(9);
            wd    = 8'($urandom);
            ack   = ($urandom_range(3) == 0);
            if (sel < 6) begin
                op = 0; addr = 8'($urandom_range(8'hDF));
            end else if (sel < 8) begin
                op = 2; addr = 8'hE0 + 8'($urandom_range(5));
            end else begin
                op = 1; addr = 8'hE0 + 8'($urandom_range(4));
            end
            // The bus is owned by the controller in a read-response cycle.
            if (m_rdv && op == 1) begin
                op = 0; addr = 8'h00;
            end
            step(r, raise, op, addr, wd, ack);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
